// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks a shadow copy of ID/EX, EX/MEM and MEM/WB and a multi-cycle mult/div in EX.
module hazard_forward_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] id_dest,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_muldiv,
    input  logic       ex_branch_taken,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       bubble,
    output logic       flush,
    output logic       ex_hold,
    output logic       muldiv_busy
);

    typedef enum logic {IDLE, BUSY} md_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } idex_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       regwrite;
    } wb_t;

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    idex_t      idex_q, idex_d;
    wb_t        exmem_q, exmem_d;
    wb_t        memwb_q, memwb_d;

    logic in_busy, flush_c, load_use, issue;
    logic dep_rs, dep_rt;

    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] src,
                                           input wb_t em, input wb_t mw);
        logic [1:0] sel;
        sel = 2'd0;
        if (uses && src != 5'd0) begin
            if (em.valid && em.regwrite && em.dest == src)
                sel = 2'd1;
            else if (mw.valid && mw.regwrite && mw.dest == src)
                sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        in_busy  = (state_q == BUSY);
        flush_c  = ex_branch_taken && !in_busy;
        dep_rs   = id_uses_rs && id_rs == idex_q.dest && id_rs != 5'd0;
        dep_rt   = id_uses_rt && id_rt == idex_q.dest && id_rt != 5'd0;
        load_use = !in_busy && idex_q.valid && idex_q.memread && id_valid
                   && (dep_rs || dep_rt) && !flush_c;
        issue    = !in_busy && id_valid && !load_use && !flush_c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = exmem_q;

        if (in_busy) begin
            exmem_d.valid = 1'b0;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            exmem_d.valid    = idex_q.valid;
            exmem_d.dest     = idex_q.dest;
            exmem_d.regwrite = idex_q.regwrite;
            // Invalidated slots are cleared entirely so stale uses_* cannot forward.
            idex_d = '0;
            if (issue) begin
                idex_d.valid    = 1'b1;
                idex_d.rs       = id_rs;
                idex_d.rt       = id_rt;
                idex_d.uses_rs  = id_uses_rs;
                idex_d.uses_rt  = id_uses_rt;
                idex_d.dest     = id_dest;
                idex_d.regwrite = id_regwrite;
                idex_d.memread  = id_memread;
                if (id_muldiv) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    always_comb begin
        fwd_a_sel   = '0;
        fwd_b_sel   = '0;
        stall       = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        ex_hold     = 1'b0;
        muldiv_busy = 1'b0;
        if (!reset) begin
            fwd_a_sel   = fwd_sel(idex_q.uses_rs, idex_q.rs, exmem_q, memwb_q);
            fwd_b_sel   = fwd_sel(idex_q.uses_rt, idex_q.rt, exmem_q, memwb_q);
            stall       = in_busy || load_use;
            bubble      = load_use;
            flush       = flush_c;
            ex_hold     = in_busy;
            muldiv_busy = in_busy;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed and random checks of hazard_forward_ctrl against an occupancy-based
// reference model of the pipeline.
module tb_hazard_forward_ctrl;

    localparam int M = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_muldiv;
    logic       ex_branch_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble, flush, ex_hold, muldiv_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.MULDIV_CYCLES(M)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_muldiv(id_muldiv), .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble(bubble),
        .flush(flush), .ex_hold(ex_hold), .muldiv_busy(muldiv_busy)
    );

    // Reference model: one record per pipeline slot; occ counts remaining EX cycles.
    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int dest; bit rw; bit mr;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int    occ;

    int e_fa, e_fb;
    bit e_stall, e_bubble, e_flush, e_hold, e_busy, m_lu;

    function automatic int fwd(bit uses, int r, slot_t mem, slot_t wb);
        if (!uses || r == 0) return 0;
        if (mem.v && mem.rw && mem.dest == r) return 1;
        if (wb.v && wb.rw && wb.dest == r) return 2;
        return 0;
    endfunction

    task automatic model_clear();
        m_ex = '{default: 0};
        m_mem = '{default: 0};
        m_wb = '{default: 0};
        occ = 0;
    endtask

    task automatic model_outputs();
        bit busy;
        busy = occ > 1;
        m_lu = !busy && m_ex.v && m_ex.mr && id_valid &&
               ((id_uses_rs && int'(id_rs) == m_ex.dest && id_rs != 0) ||
                (id_uses_rt && int'(id_rt) == m_ex.dest && id_rt != 0));
        e_flush  = !busy && ex_branch_taken;
        m_lu     = m_lu && !e_flush;
        e_stall  = busy || m_lu;
        e_bubble = m_lu;
        e_hold   = busy;
        e_busy   = busy;
        e_fa     = fwd(m_ex.urs, m_ex.rs, m_mem, m_wb);
        e_fb     = fwd(m_ex.urt, m_ex.rt, m_mem, m_wb);
        if (reset) begin
            e_fa = 0; e_fb = 0;
            e_stall = 0; e_bubble = 0; e_flush = 0; e_hold = 0; e_busy = 0;
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            model_clear();
        end else if (occ > 1) begin
            m_wb = m_mem;
            m_mem = '{default: 0};
            occ--;
        end else begin
            bit enter;
            enter = id_valid && !m_lu && !e_flush;
            m_wb = m_mem;
            m_mem = m_ex;
            m_ex = '{default: 0};
            occ = 0;
            if (enter) begin
                m_ex = '{v: 1, rs: id_rs, rt: id_rt, urs: id_uses_rs, urt: id_uses_rt,
                         dest: id_dest, rw: id_regwrite, mr: id_memread};
                if (id_muldiv) occ = M;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dest, input bit rw, input bit mr, input bit md, input bit br);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_dest = 5'(dest); id_regwrite = rw; id_memread = mr; id_muldiv = md;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare all outputs to the model, then take one clock edge.
    task automatic tick();
        #1;
        model_outputs();
        chk("fwd_a_sel", int'(fwd_a_sel), e_fa);
        chk("fwd_b_sel", int'(fwd_b_sel), e_fb);
        chk("stall", int'(stall), int'(e_stall));
        chk("bubble", int'(bubble), int'(e_bubble));
        chk("flush", int'(flush), int'(e_flush));
        chk("ex_hold", int'(ex_hold), int'(e_hold));
        chk("muldiv_busy", int'(muldiv_busy), int'(e_busy));
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        drive(1, 3, 3, 1, 1, 3, 1, 1, 1, 1);
        @(negedge clk);
        #1;
        chk("reset_stall", int'(stall), 0);
        chk("reset_flush", int'(flush), 0);
        tick();
        tick();
        reset = 1'b0;
        nop();
        tick();

        // ADD r3 ; SUB r4,r3,r1 back-to-back
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0); tick();
        nop(); #1; chk("fwd_exmem", int'(fwd_a_sel), 1); tick();
        tick(); tick();
        // one NOP between
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        nop(); tick();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0); tick();
        nop(); #1; chk("fwd_memwb", int'(fwd_a_sel), 2); tick();
        tick(); tick();
        // r0 destination never forwarded
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 1, 1, 4, 1, 0, 0, 0); tick();
        nop(); #1; chk("fwd_r0", int'(fwd_a_sel), 0); tick();
        tick(); tick();

        // LW r5 ; ADD r6,r5,r2 load-use
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
        #1; chk("lu_stall", int'(stall), 1); chk("lu_bubble", int'(bubble), 1);
        tick();
        #1; chk("lu_release", int'(stall), 0);
        tick();
        nop(); #1; chk("lu_fwd", int'(fwd_a_sel), 2); tick();
        tick(); tick();

        // load-use overridden by a taken branch
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 1);
        #1; chk("br_flush", int'(flush), 1); chk("br_stall", int'(stall), 0);
        chk("br_bubble", int'(bubble), 0);
        tick();
        nop(); tick(); tick(); tick();

        // ADD r7 ; MULT r8 <- r7 : older ADD drains while MULT holds EX
        drive(1, 1, 2, 1, 1, 7, 1, 0, 0, 0); tick();
        drive(1, 7, 0, 1, 0, 8, 1, 0, 1, 0); tick();
        nop();
        #1; chk("md_busy1", int'(muldiv_busy), 1); chk("md_fwd_exmem", int'(fwd_a_sel), 1);
        tick();
        #1; chk("md_busy2", int'(ex_hold), 1); chk("md_fwd_memwb", int'(fwd_a_sel), 2);
        tick();
        #1; chk("md_busy3", int'(muldiv_busy), 1); chk("md_fwd_none", int'(fwd_a_sel), 0);
        tick();
        drive(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
        #1; chk("md_done", int'(muldiv_busy), 0); chk("md_hold_done", int'(ex_hold), 0);
        tick();
        nop(); #1; chk("md_result_fwd", int'(fwd_a_sel), 1); tick();
        tick(); tick();

        // reset during second BUSY cycle
        drive(1, 1, 0, 1, 0, 8, 1, 0, 1, 0); tick();
        nop(); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        #1; chk("rst_busy", int'(muldiv_busy), 0); chk("rst_stall", int'(stall), 0);
        tick();
        tick();

        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, default 4, EX-stage occupancy of a mult/div instruction in cycles (legal range 2..15).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: id_valid  in  1  ID stage holds a real instruction.
REQ-005 Port: id_rs, id_rt  in  5 each  ID source register numbers.
REQ-006 Port: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 Port: id_dest  in  5  ID destination register number.
REQ-008 Port: id_regwrite, id_memread, id_muldiv  in  1 each  ID instruction writes a register / is a load / is a mult or div.
REQ-009 Port: ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 Port: fwd_a_sel, fwd_b_sel  out  2 each  select for the EX operand Mux4_32b: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result; 3 never driven.
REQ-011 Port: stall  out  1  hold PC and IF/ID.
REQ-012 Port: bubble  out  1  load a NOP into ID/EX.
REQ-013 Port: flush  out  1  kill IF/ID and ID/EX contents.
REQ-014 Port: ex_hold  out  1  hold ID/EX; EX/MEM receives a NOP.
REQ-015 Port: muldiv_busy  out  1  mult/div occupying EX.

Function
REQ-016 Shadow pipeline SHALL be kept in three registered stages: IDEX {valid, rs, rt, uses_rs, uses_rt, dest, regwrite, memread}, EXMEM {valid, dest, regwrite}, MEMWB {valid, dest, regwrite}.
REQ-017 Normal cycle: IDEX<-ID inputs, EXMEM<-IDEX, MEMWB<-EXMEM.
REQ-018 Forwarding (combinational from shadow state): fwd_a_sel=1 if IDEX.uses_rs, EXMEM.valid, EXMEM.regwrite, EXMEM.dest==IDEX.rs and IDEX.rs!=0; else 2 under the same test on MEMWB; else 0. fwd_b_sel is identical using rt.
REQ-019 EXMEM match SHALL have priority over MEMWB match; register 0 SHALL never be forwarded.
REQ-020 Load-use: when IDEX.valid, IDEX.memread and id_valid, with (id_uses_rs, id_rs==IDEX.dest, id_rs!=0) or (id_uses_rt, id_rt==IDEX.dest, id_rt!=0), assert stall=1 and bubble=1 for exactly one cycle; IDEX.valid<-0 next edge.
REQ-021 Branch: ex_branch_taken=1 asserts flush=1 in the same cycle; next edge IDEX.valid<-0; flush overrides load-use, so stall=0 and bubble=0 that cycle.
REQ-022 Mult/div FSM states IDLE, BUSY; 4-bit down-counter cnt.
REQ-023 IDLE->BUSY when an instruction with id_muldiv=1 enters IDEX (not stalled, not flushed); cnt<-MULDIV_CYCLES-1.
REQ-024 In BUSY: muldiv_busy=1, stall=1, ex_hold=1, bubble=0; IDEX holds; EXMEM.valid<-0; MEMWB<-EXMEM; cnt decrements each cycle.
REQ-025 BUSY->IDLE on the edge where cnt==1 (cnt becomes 0); the next cycle is a normal cycle and the mult/div advances to EXMEM.
REQ-026 ex_branch_taken SHALL be ignored while in BUSY.
REQ-027 Load-use check SHALL be suppressed in BUSY; it is re-evaluated in the first IDLE cycle.
REQ-028 Total EX occupancy of a mult/div SHALL equal MULDIV_CYCLES cycles.

Reset
REQ-029 reset=1 at a rising edge SHALL clear all shadow valid bits, set cnt=0, and enter IDLE, including mid-BUSY.
REQ-030 While reset=1, all outputs SHALL be 0: fwd_a_sel=fwd_b_sel=0, stall=bubble=flush=ex_hold=muldiv_busy=0.
REQ-031 First cycle after reset deasserts: no forwarding, no stall, until valid instructions propagate.

Verification
REQ-032 ADD r3 then SUB r4,r3,r1 back-to-back -> SUB in EX sees fwd_a_sel=1; with one NOP between -> fwd_a_sel=2; with r0 as dest -> fwd_a_sel=0.
REQ-033 LW r5 then ADD r6,r5,r2 -> one cycle stall=1, bubble=1; ADD then in EX with fwd_a_sel=2.
REQ-034 LW r5 in IDEX, dependent ADD in ID, ex_branch_taken=1 same cycle -> flush=1, stall=0, bubble=0.
REQ-035 MULT issued with MULDIV_CYCLES=4 -> muldiv_busy=1 and ex_hold=1 for 3 cycles, then deassert; MULT occupies EX 4 cycles total; an older instruction in EXMEM still reaches MEMWB.
REQ-036 reset=1 during second BUSY cycle -> next cycle all outputs 0, IDLE, cnt=0.
